// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, branch redirect and
// out-of-range redirect trap. All outputs come straight from flops.
module fetch_stage #(
  parameter int               WIDTH      = 32,
  parameter int               IMEM_DEPTH = 512,
  parameter logic [WIDTH-1:0] NOP        = WIDTH'(32'h00000013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] imem_rd,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] ifid_instr,
  output logic [WIDTH-1:0] ifid_pc,
  output logic [WIDTH-1:0] ifid_pc_plus1,
  output logic             ifid_valid,
  output logic             fetch_err
);

  // state | meaning
  // IDLE  | single settle cycle after reset, PC held at 0, nothing captured
  // RUN   | fetching: redirect > stall > sequential advance
  // ERR   | redirect target was out of range; frozen until reset
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(IMEM_DEPTH);
  localparam logic [WIDTH-1:0] LAST_PC = WIDTH'(IMEM_DEPTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt, instr_nxt, ifpc_nxt, plus1_nxt;
  logic             valid_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc_o          <= '0;
      ifid_instr    <= NOP;
      ifid_pc       <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc_o          <= pc_nxt;
      ifid_instr    <= instr_nxt;
      ifid_pc       <= ifpc_nxt;
      ifid_pc_plus1 <= plus1_nxt;
      ifid_valid    <= valid_nxt;
      fetch_err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_o;
    instr_nxt = ifid_instr;
    ifpc_nxt  = ifid_pc;
    plus1_nxt = ifid_pc_plus1;
    valid_nxt = ifid_valid;
    err_nxt   = fetch_err;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (redirect_valid) begin
          // squash the slot; ifid_pc/ifid_pc_plus1 keep their last values
          instr_nxt = NOP;
          valid_nxt = 1'b0;
          if (redirect_pc < DEPTH_W) begin
            pc_nxt = redirect_pc;
          end else begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end
        end else if (!stall) begin
          instr_nxt = imem_rd;
          ifpc_nxt  = pc_o;
          plus1_nxt = pc_o + ONE;
          valid_nxt = 1'b1;
          pc_nxt    = (pc_o == LAST_PC) ? '0 : pc_o + ONE;
        end
      end
      ERR: begin
        instr_nxt = NOP;
        valid_nxt = 1'b0;
        err_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random stimulus, each
// cycle checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int DEPTH = 512;
  localparam logic [31:0] NOPI = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_rd;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_o, ifid_instr, ifid_pc, ifid_pc_plus1;
  logic        ifid_valid, fetch_err;

  logic [31:0] mem [DEPTH];

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_rd(imem_rd), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_o(pc_o), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  assign imem_rd = (pc_o < DEPTH) ? mem[pc_o[8:0]] : 32'hdeadbeef;

  typedef struct packed {
    logic [31:0] pc, instr, ipc, plus1;
    logic        valid, err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // model: phase 0 = settle cycle after reset, 1 = running, 2 = trapped
  int          m_phase;
  int unsigned m_pc, m_ipc, m_plus1;
  logic [31:0] m_instr;
  logic        m_valid, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit rv, input int unsigned rpc);
    if (r) begin
      m_phase = 0; m_pc = 0; m_ipc = 0; m_plus1 = 0;
      m_instr = NOPI; m_valid = 0; m_err = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (rv) begin
        m_instr = NOPI; m_valid = 0;
        if (rpc < DEPTH) m_pc = rpc;
        else begin m_phase = 2; m_err = 1; end
      end else if (!s) begin
        m_instr = mem[m_pc];
        m_ipc   = m_pc;
        m_plus1 = m_pc + 1;
        m_valid = 1;
        m_pc    = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit rv, input int unsigned rpc);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    model_edge(r, s, rv, rpc);
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.plus1 = m_plus1;
    e.valid = m_valid; e.err = m_err;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc", ifid_pc, e.ipc);
        chk("ifid_pc_plus1", ifid_pc_plus1, e.plus1);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, e.err});
      end
    end
  end

  initial begin : driver
    int unsigned rpc;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h00000113;
    mem[1] = 32'h00400093;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // reset release sequence
    step(0, 1, 1, 77);
    @(posedge clk); #1;
    chk("idle_pc", pc_o, 0);
    chk("idle_valid", {31'b0, ifid_valid}, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk); #1;
    chk("first_instr1", ifid_instr, 32'h00400093);
    chk("first_pc1", ifid_pc, 1);
    chk("first_plus1", ifid_pc_plus1, 2);

    // stall hold at pc 5
    repeat (3) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // redirect beats stall
    step(0, 0, 1, 105);
    step(0, 0, 0, 0);
    step(0, 1, 1, 87);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // wrap at the top of memory
    step(0, 0, 1, 500);
    repeat (12) step(0, 0, 0, 0);
    @(posedge clk); #1;
    chk("wrap_pc", pc_o, 0);
    chk("wrap_ifid_pc", ifid_pc, 511);
    chk("wrap_plus1", ifid_pc_plus1, 512);

    // out-of-range redirect traps
    step(0, 0, 1, 600);
    step(0, 0, 1, 3);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk); #1;
    chk("err_sticky", {31'b0, fetch_err}, 1);
    step(1, 0, 1, 3);
    step(0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);

    // reset on the same edge as a redirect
    step(0, 0, 1, 200);
    step(1, 0, 1, 50);
    repeat (3) step(0, 0, 0, 0);

    // random
    for (int n = 0; n < 4000; n++) begin
      rpc = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, DEPTH + 2000)
                                         : $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 7) == 0) rpc = DEPTH - 1;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, rpc);
    end

    step(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
